uart_core: RTL
==============

Name: uart_core

Overview:
- UART peripheral that answers the j1 CPU's UART I/O port: byte write strobe and busy on the TX side; valid, data and read-acknowledge strobe on the RX side.
- 8N1 serialiser and deserialiser with a shared baud divisor.
- Small first-word-fall-through RX FIFO, so the CPU can poll without losing back-to-back bytes.
- Sits between the CPU I/O decode and the board's RXD/TXD pins.

Parameters:
CLKS_PER_BIT, 104, clk cycles per serial bit; legal range 4..65535.
FIFO_DEPTH, 4, RX FIFO entries; must be a power of 2, at least 2.

Ports:
clk  input  1  system clock; all logic rises on this edge.
reset  input  1  synchronous, active-high reset.
uart_rxd  input  1  serial input, asynchronous, idles high.
uart_txd  output  1  serial output, idles high.
wr  input  1  one-cycle strobe: load tx_data for transmission.
tx_data  input  8  byte to transmit; sampled only when wr=1.
busy  output  1  transmitter occupied; writes are ignored while high.
rd  input  1  one-cycle strobe: pop the FIFO head.
valid  output  1  FIFO not empty.
rx_data  output  8  FIFO head byte; 8'h00 when valid=0.
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte dropped.
overrun  output  1  one-cycle pulse: byte received while FIFO full, byte dropped.

Behaviour:
- Reset (synchronous, active-high): txd=1, busy=0, valid=0, rx_data=0, frame_err=0, overrun=0. FIFO is emptied; both FSMs go to IDLE; counters are cleared. Reset mid-frame abandons the frame at the next edge, with txd forced to 1.

TX FSM: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE.
- wr=1 in TX_IDLE at edge N latches tx_data. At N+1: busy=1, txd=0.
- Each state lasts CLKS_PER_BIT cycles. Data is sent LSB first, 8 bits, then a stop bit of 1.
- busy falls on the cycle the stop bit ends, i.e. 10*CLKS_PER_BIT cycles after it rose. wr is accepted again that same cycle; there is no idle gap.
- wr while busy=1: ignored, with no queuing.

RX input sync: two flip-flops on uart_rxd; all RX logic uses the synchronised signal.

RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
- RX_IDLE: a synchronised 1->0 transition enters RX_START, with the counter loaded to CLKS_PER_BIT/2 (integer divide).
- RX_START: at half-bit, line still 0 -> RX_DATA. Line 1 -> glitch; return to RX_IDLE with no output.
- RX_DATA: sample every CLKS_PER_BIT cycles, shifting LSB first; after 8 samples go to RX_STOP.
- RX_STOP: sample after one more CLKS_PER_BIT.
  - Sample 1 -> push byte to FIFO.
  - Sample 0 -> frame_err pulse, byte discarded.
  - Either way return to RX_IDLE.
- After a framing error, a new start bit is recognised only after the line returns high.

FIFO (first-word fall-through):
- valid and rx_data reflect the head combinationally from registered storage.
- Push on the cycle after the stop sample. The byte is visible on valid/rx_data one cycle after the push.
- rd with valid=1 pops; the next entry appears the following cycle.
- rd with valid=0: ignored.
- Push while full, no rd: overrun pulse, new byte dropped, contents unchanged.
- Push and rd in the same cycle while full: both succeed, count unchanged, no overrun.
- Push and rd in the same cycle while empty: rd ignored, push succeeds.
- Pointers are log2(FIFO_DEPTH) bits and wrap. The count is one bit wider, to tell full from empty.

Width rules: bit counters are 3 bits; the divisor counter is $clog2(CLKS_PER_BIT) bits, counting down to 0.

Decomposition:
- Package uart_pkg:
  - TX/RX state encodings (2-bit enums).
  - IDLE_LEVEL=1'b1, DATA_BITS=8.
  - Function computing the half-bit load value.
- Sub-module uart_rx_fifo (parameter DEPTH, width 8):
  - ports clk, reset, push, push_data, pop, valid, head, full, overrun.
- The TX and RX FSMs stay in uart_core.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset, then wr with tx_data=8'hA5 -> busy=1 for 40 cycles. txd = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. After that busy=0 and txd=1.
2. wr 8'h3C while busy (issued 10 cycles into the frame) -> ignored; the frame on txd stays 8'hA5.
3. Drive RX frame 8'h5A -> valid=1, rx_data=8'h5A. Pulse rd -> next cycle valid=0, rx_data=8'h00.
4. Drive a 1-cycle low glitch on rxd -> no push, valid stays 0, no frame_err.
5. Drive frame 8'hFF with the stop bit held low -> frame_err one-cycle pulse, valid stays 0.
6. Send 5 frames 8'h01..8'h05 with no rd:
   - 5th byte -> overrun pulse.
   - Four rd pops read 01,02,03,04; then valid=0.
   - Repeat with rd coinciding with the 5th push -> no overrun; pops read 02,03,04,05.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_core slice.
//   - 2-bit TX and RX FSM state encodings
//   - serial line idle level and data width
//   - helper returning the divisor load used to reach mid start bit
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'b00,
      TX_START = 2'b01,
      TX_DATA  = 2'b10,
      TX_STOP  = 2'b11
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'b00,
      RX_START = 2'b01,
      RX_DATA  = 2'b10,
      RX_STOP  = 2'b11
   } rx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;
   localparam int   DATA_BITS  = 8;

   // Divisor load applied on a detected start edge (integer half of a bit).
   function automatic int half_bit_load(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO for received data.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   push, push_data write strobe and byte
//   pop             read strobe; ignored while empty
//   valid, head     FIFO not empty and the head byte (8'h00 when empty)
//   full            all DEPTH entries occupied
//   overrun         one-cycle pulse: push refused because the FIFO was full
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] push_data,
   input  logic                 pop,
   output logic                 valid,
   output logic [DATA_BITS-1:0] head,
   output logic                 full,
   output logic                 overrun
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATA_BITS-1:0] mem_r [DEPTH];
   logic [AW-1:0]        wr_ptr_r;
   logic [AW-1:0]        rd_ptr_r;
   logic [CW-1:0]        count_r;
   logic                 overrun_r;
   logic                 pop_ok_s;
   logic                 push_ok_s;

   assign full    = (count_r == CW'(DEPTH));
   assign valid   = (count_r != '0);
   assign head    = valid ? mem_r[rd_ptr_r] : '0;
   assign overrun = overrun_r;

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   always_comb begin
      pop_ok_s  = pop && (count_r != '0);
      push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
   end

   // Storage, wrapping pointers, occupancy count and overrun pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         overrun_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
         overrun_r <= push && full && !pop_ok_s;
      end
   end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART for the j1 CPU I/O port.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   uart_rxd         asynchronous serial input (idles high)
//   uart_txd         serial output (idles high)
//   wr, tx_data      one-cycle transmit strobe and byte; ignored while busy
//   busy             transmitter occupied
//   rd               one-cycle strobe popping the RX FIFO head
//   valid, rx_data   RX FIFO not empty and its head byte (8'h00 when empty)
//   frame_err        one-cycle pulse: stop bit sampled low, byte dropped
//   overrun          one-cycle pulse: byte arrived with the FIFO full, dropped
module uart_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic       uart_txd,
   input  logic       wr,
   input  logic [7:0] tx_data,
   output logic       busy,
   input  logic       rd,
   output logic       valid,
   output logic [7:0] rx_data,
   output logic       frame_err,
   output logic       overrun
);

   localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit_load(CLKS_PER_BIT));
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   // ---------------- transmitter ----------------
   tx_state_t            tx_state_r, tx_state_s;
   logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_s;
   logic [2:0]           tx_bit_r, tx_bit_s;
   logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
   logic                 txd_r, txd_s;
   logic                 busy_r, busy_s;

   assign uart_txd = txd_r;
   assign busy     = busy_r;

   // TX next state: each state holds the line for one full bit period.
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_bit_s   = tx_bit_r;
      tx_shift_s = tx_shift_r;
      txd_s      = txd_r;
      busy_s     = busy_r;
      case (tx_state_r)
         TX_IDLE: begin
            if (wr) begin
               tx_state_s = TX_START;
               tx_cnt_s   = BIT_LOAD;
               tx_bit_s   = 3'd0;
               tx_shift_s = tx_data;
               txd_s      = 1'b0;
               busy_s     = 1'b1;
            end else begin
               txd_s  = IDLE_LEVEL;
               busy_s = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_r == '0) begin
               tx_state_s = TX_DATA;
               tx_cnt_s   = BIT_LOAD;
               tx_bit_s   = 3'd0;
               txd_s      = tx_shift_r[0];
               tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
            end else begin
               tx_cnt_s = tx_cnt_r - CNT_W'(1'b1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_r == '0) begin
               tx_cnt_s = BIT_LOAD;
               if (tx_bit_r == LAST_BIT) begin
                  tx_state_s = TX_STOP;
                  txd_s      = 1'b1;
               end else begin
                  tx_bit_s   = tx_bit_r + 3'd1;
                  txd_s      = tx_shift_r[0];
                  tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
               end
            end else begin
               tx_cnt_s = tx_cnt_r - CNT_W'(1'b1);
            end
         end
         TX_STOP: begin
            // Returning to idle here lets a wr in the very next cycle start a frame.
            if (tx_cnt_r == '0) begin
               tx_state_s = TX_IDLE;
               txd_s      = IDLE_LEVEL;
               busy_s     = 1'b0;
            end else begin
               tx_cnt_s = tx_cnt_r - CNT_W'(1'b1);
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            txd_s      = IDLE_LEVEL;
            busy_s     = 1'b0;
         end
      endcase
   end

   // TX state and registered line/busy outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= '0;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= '0;
         txd_r      <= IDLE_LEVEL;
         busy_r     <= 1'b0;
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_bit_r   <= tx_bit_s;
         tx_shift_r <= tx_shift_s;
         txd_r      <= txd_s;
         busy_r     <= busy_s;
      end
   end

   // ---------------- receiver ----------------
   logic                 rx_meta_r, rx_sync_r, rx_prev_r;
   rx_state_t            rx_state_r, rx_state_s;
   logic [CNT_W-1:0]     rx_cnt_r, rx_cnt_s;
   logic [2:0]           rx_bit_r, rx_bit_s;
   logic [DATA_BITS-1:0] rx_shift_r, rx_shift_s;
   logic                 rx_push_r, rx_push_s;
   logic                 frame_err_r, frame_err_s;

   assign frame_err = frame_err_r;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_r <= IDLE_LEVEL;
         rx_sync_r <= IDLE_LEVEL;
         rx_prev_r <= IDLE_LEVEL;
      end else begin
         rx_meta_r <= uart_rxd;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // RX next state: requiring a 1->0 edge means a line stuck low after a
   // framing error cannot start a new frame until it has gone high again.
   always_comb begin
      rx_state_s  = rx_state_r;
      rx_cnt_s    = rx_cnt_r;
      rx_bit_s    = rx_bit_r;
      rx_shift_s  = rx_shift_r;
      rx_push_s   = 1'b0;
      frame_err_s = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (rx_prev_r && !rx_sync_r) begin
               rx_state_s = RX_START;
               rx_cnt_s   = HALF_LOAD;
            end else begin
               rx_state_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == '0) begin
               if (!rx_sync_r) begin
                  rx_state_s = RX_DATA;
                  rx_cnt_s   = BIT_LOAD;
                  rx_bit_s   = 3'd0;
               end else begin
                  rx_state_s = RX_IDLE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r - CNT_W'(1'b1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == '0) begin
               rx_shift_s = {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
               rx_cnt_s   = BIT_LOAD;
               if (rx_bit_r == LAST_BIT) begin
                  rx_state_s = RX_STOP;
               end else begin
                  rx_bit_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r - CNT_W'(1'b1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == '0) begin
               rx_state_s = RX_IDLE;
               if (rx_sync_r) begin
                  rx_push_s = 1'b1;
               end else begin
                  frame_err_s = 1'b1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r - CNT_W'(1'b1);
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
         end
      endcase
   end

   // RX state, registered push strobe and framing-error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_r  <= RX_IDLE;
         rx_cnt_r    <= '0;
         rx_bit_r    <= 3'd0;
         rx_shift_r  <= '0;
         rx_push_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_state_r  <= rx_state_s;
         rx_cnt_r    <= rx_cnt_s;
         rx_bit_r    <= rx_bit_s;
         rx_shift_r  <= rx_shift_s;
         rx_push_r   <= rx_push_s;
         frame_err_r <= frame_err_s;
      end
   end

   // The shift register is untouched in the cycle after the stop sample, so it
   // feeds the FIFO directly alongside the registered push strobe.
   uart_rx_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push_r),
      .push_data (rx_shift_r),
      .pop       (rd),
      .valid     (valid),
      .head      (rx_data),
      .full      (),
      .overrun   (overrun)
   );

endmodule
